// File: rtl/spi_flash_reader_if.sv
// Request, read-data and byte-controller signals of the SPI flash reader.
// The slave modport is the reader's view; master is the system/bench view.
interface spi_flash_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;

    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic        busy;

    logic        cs;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        spi_busy;
    logic [7:0]  spi_data_out;

    modport slave (
        input  req_valid, req_addr, req_len, rd_ready, spi_busy, spi_data_out,
        output req_ready, rd_data, rd_valid, done, busy, cs, spi_start, spi_data_in
    );

    modport master (
        output req_valid, req_addr, req_len, rd_ready, spi_busy, spi_data_out,
        input  req_ready, rd_data, rd_valid, done, busy, cs, spi_start, spi_data_in
    );
endinterface

// File: rtl/spi_flash_reader.sv
// Sequences a flash READ (opcode, 24-bit address, dummy bytes) through an
// external byte controller, owning cs and streaming bytes via a 1-entry buffer.
module spi_flash_reader #(
    parameter logic [7:0]  READ_CMD        = 8'h03,
    parameter int unsigned CS_SETUP_CYCLES = 2,
    parameter int unsigned CS_HOLD_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_flash_reader_if.slave bus
);

    localparam int unsigned CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                                      CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST     = CNT_W'(CS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST      = CNT_W'(CS_HOLD_CYCLES - 1);
    localparam logic [16:0]      FIRST_DATA_IDX = 17'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_STALL,
        S_HOLD,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [23:0]      r_addr;
    logic [15:0]      r_len;
    logic [16:0]      r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cs;
    logic             r_spi_start;
    logic [7:0]       r_spi_data_in;
    logic             r_spi_busy_d;
    logic             r_rd_valid;
    logic [7:0]       r_rd_data;
    logic             r_done;
    logic             r_busy;
    logic             r_req_ready;

    state_t           w_state_nxt;
    logic [23:0]      w_addr_nxt;
    logic [15:0]      w_len_nxt;
    logic [16:0]      w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cs_nxt;
    logic             w_spi_start_nxt;
    logic [7:0]       w_spi_data_in_nxt;
    logic             w_rd_valid_nxt;
    logic [7:0]       w_rd_data_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_req_ready_nxt;

    logic [16:0]      w_last_idx;
    logic             w_busy_fall;
    logic             w_rd_pop;

    // 17-bit index so that len=65535 (last index 65538) cannot wrap.
    assign w_last_idx  = {1'b0, r_len} + 17'd3;
    assign w_busy_fall = r_spi_busy_d & ~bus.spi_busy;
    assign w_rd_pop    = r_rd_valid & bus.rd_ready;

    function automatic logic [7:0] tx_byte(input logic [16:0] idx, input logic [23:0] addr);
        case (idx)
            17'd0:   tx_byte = READ_CMD;
            17'd1:   tx_byte = addr[23:16];
            17'd2:   tx_byte = addr[15:8];
            17'd3:   tx_byte = addr[7:0];
            default: tx_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_len_nxt         = r_len;
        w_idx_nxt         = r_idx;
        w_cnt_nxt         = r_cnt;
        w_cs_nxt          = r_cs;
        w_spi_start_nxt   = r_spi_start;
        w_spi_data_in_nxt = r_spi_data_in;
        w_rd_valid_nxt    = r_rd_valid;
        w_rd_data_nxt     = r_rd_data;
        w_done_nxt        = 1'b0;
        w_busy_nxt        = r_busy;
        w_req_ready_nxt   = r_req_ready;

        if (w_rd_pop) begin
            w_rd_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (bus.req_valid && r_req_ready) begin
                    w_addr_nxt      = bus.req_addr;
                    w_len_nxt       = bus.req_len;
                    w_busy_nxt      = 1'b1;
                    w_req_ready_nxt = 1'b0;
                    if (bus.req_len == 16'd0) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_cs_nxt    = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt       = S_ISSUE;
                    w_idx_nxt         = 17'd0;
                    w_spi_start_nxt   = 1'b1;
                    w_spi_data_in_nxt = tx_byte(17'd0, r_addr);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_ISSUE: begin
                if (bus.spi_busy) begin
                    w_spi_start_nxt = 1'b0;
                    w_state_nxt     = S_WAIT;
                end
            end

            S_WAIT: begin
                if (w_busy_fall) begin
                    // Capture only ever happens into an empty buffer: a data
                    // byte is issued only after the previous one has drained.
                    if (r_idx >= FIRST_DATA_IDX) begin
                        w_rd_valid_nxt = 1'b1;
                        w_rd_data_nxt  = bus.spi_data_out;
                    end
                    if (r_idx == w_last_idx) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 17'd1;
                        if (w_rd_valid_nxt) begin
                            w_state_nxt = S_STALL;
                        end else begin
                            w_state_nxt       = S_ISSUE;
                            w_spi_start_nxt   = 1'b1;
                            w_spi_data_in_nxt = tx_byte(r_idx + 17'd1, r_addr);
                        end
                    end
                end
            end

            S_STALL: begin
                if (!r_rd_valid) begin
                    w_state_nxt       = S_ISSUE;
                    w_spi_start_nxt   = 1'b1;
                    w_spi_data_in_nxt = tx_byte(r_idx, r_addr);
                end
            end

            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cs_nxt    = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_FIN: begin
                if (!r_rd_valid) begin
                    w_done_nxt      = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_cs          <= 1'b1;
            r_spi_start   <= 1'b0;
            r_spi_data_in <= '0;
            r_spi_busy_d  <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_req_ready   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_len         <= w_len_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cs          <= w_cs_nxt;
            r_spi_start   <= w_spi_start_nxt;
            r_spi_data_in <= w_spi_data_in_nxt;
            r_spi_busy_d  <= bus.spi_busy;
            r_rd_valid    <= w_rd_valid_nxt;
            r_rd_data     <= w_rd_data_nxt;
            r_done        <= w_done_nxt;
            r_busy        <= w_busy_nxt;
            r_req_ready   <= w_req_ready_nxt;
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.cs          = r_cs;
    assign bus.spi_start   = r_spi_start;
    assign bus.spi_data_in = r_spi_data_in;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench: byte-controller/flash model with delayed busy, read-data
// consumer, and hand-computed expectations for each scenario.
module tb_spi_flash_reader;

    localparam int CLK_DIVIDER = 4;
    localparam int BUSY_DELAY  = 2;
    localparam int BYTE_CYCLES = 4 * CLK_DIVIDER;

    logic clk = 1'b0;
    logic reset = 1'b0;

    spi_flash_reader_if bus ();

    spi_flash_reader #(
        .READ_CMD        (8'h03),
        .CS_SETUP_CYCLES (2),
        .CS_HOLD_CYCLES  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flash contents: two fixed bytes, everything else addr[7:0]^3C.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h012345)      flash_byte = 8'hA5;
        else if (a == 24'h012346) flash_byte = 8'h5A;
        else                      flash_byte = a[7:0] ^ 8'h3C;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Byte controller + flash model, driven on the falling edge.
    logic [7:0]  tx_q[$];
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_bc = 0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_resp = '0;
    int          n_viol = 0;

    always @(negedge clk) begin
        if (!reset) begin
            m_phase          = 0;
            m_cnt            = 0;
            m_bc             = 0;
            bus.spi_busy     = 1'b0;
            bus.spi_data_out = 8'h00;
        end else begin
            if (bus.cs) m_bc = 0;
            case (m_phase)
                0: if (bus.spi_start) begin
                    tx_q.push_back(bus.spi_data_in);
                    if (m_bc == 1) m_addr[23:16] = bus.spi_data_in;
                    if (m_bc == 2) m_addr[15:8]  = bus.spi_data_in;
                    if (m_bc == 3) m_addr[7:0]   = bus.spi_data_in;
                    m_resp  = (m_bc >= 4) ? flash_byte(m_addr + 24'(m_bc - 4)) : 8'hFF;
                    m_bc++;
                    m_phase = 1;
                    m_cnt   = BUSY_DELAY;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        bus.spi_busy = 1'b1;
                        m_phase      = 2;
                        m_cnt        = BYTE_CYCLES;
                    end
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        bus.spi_busy     = 1'b0;
                        bus.spi_data_out = m_resp;
                        if (bus.spi_start) n_viol++;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    // Passive monitor of the reader outputs.
    logic [7:0] rx_q[$];
    int   n_done = 0;
    int   done_cyc = 0;
    int   n_cs_falls = 0;
    int   n_starts = 0;
    int   n_stall_start = 0;
    logic m_cs_d = 1'b1;
    logic m_start_d = 1'b0;

    always @(negedge clk) begin
        if (bus.rd_valid && bus.rd_ready) rx_q.push_back(bus.rd_data);
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (m_cs_d && !bus.cs) n_cs_falls++;
        if (bus.spi_start && !m_start_d) n_starts++;
        if (bus.spi_start && bus.rd_valid) n_stall_start++;
        m_cs_d    = bus.cs;
        m_start_d = bus.spi_start;
    end

    int acc_cyc = 0;

    task automatic do_req(input logic [23:0] addr, input logic [15:0] len, input string tag);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        acc_cyc       = cyc;
        bus.req_valid = 1'b0;
        check({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int base, input int limit, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (n_done > base) ok = 1'b1;
        end
        check({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    task automatic cmp_bytes(input string tag, input logic use_rx, input int base,
                             input logic [7:0] exp[$]);
        int sz;
        logic [7:0] got;
        sz = use_rx ? rx_q.size() : tx_q.size();
        check({tag, "_count"}, 32'(sz - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < sz) got = use_rx ? rx_q[base + i] : tx_q[base + i];
            else               got = 8'hxx;
            check($sformatf("%s_%0d", tag, i), 32'(got), 32'(exp[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"},          32'(bus.cs),          32'd1);
        check({tag, "_spi_start"},   32'(bus.spi_start),   32'd0);
        check({tag, "_spi_data_in"}, 32'(bus.spi_data_in), 32'h00);
        check({tag, "_rd_valid"},    32'(bus.rd_valid),    32'd0);
        check({tag, "_rd_data"},     32'(bus.rd_data),     32'h00);
        check({tag, "_done"},        32'(bus.done),        32'd0);
        check({tag, "_busy"},        32'(bus.busy),        32'd0);
        check({tag, "_req_ready"},   32'(bus.req_ready),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp[$];
        int tx_b, rx_b, dn_b, cs_b, st_b, ss_b;
        int cs_high, start_high;
        logic ok;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.rd_ready  = 1'b1;

        // Reset state, then req_ready rises on the first edge after release.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rst_release_req_ready", 32'(bus.req_ready), 32'd1);

        // Basic read: addr 012345, len 2.
        tx_b = tx_q.size(); rx_b = rx_q.size(); dn_b = n_done; cs_b = n_cs_falls; st_b = n_starts;
        do_req(24'h012345, 16'd2, "t1");
        check("t1_busy", 32'(bus.busy), 32'd1);
        wait_done(dn_b, 2000, "t1");
        exp = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};
        cmp_bytes("t1_tx", 1'b0, tx_b, exp);
        exp = '{8'hA5, 8'h5A};
        cmp_bytes("t1_rx", 1'b1, rx_b, exp);
        repeat (5) @(negedge clk);
        check("t1_done_pulses", 32'(n_done - dn_b), 32'd1);
        check("t1_cs_windows", 32'(n_cs_falls - cs_b), 32'd1);
        check("t1_starts", 32'(n_starts - st_b), 32'd6);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_cs", 32'(bus.cs), 32'd1);

        // Zero-length request: quick done, no bus activity.
        tx_b = tx_q.size(); dn_b = n_done; cs_b = n_cs_falls; st_b = n_starts;
        do_req(24'h000100, 16'd0, "t2");
        wait_done(dn_b, 20, "t2");
        check("t2_latency_le3", 32'((done_cyc - acc_cyc) <= 3), 32'd1);
        check("t2_cs_windows", 32'(n_cs_falls - cs_b), 32'd0);
        check("t2_starts", 32'(n_starts - st_b), 32'd0);
        check("t2_tx", 32'(tx_q.size() - tx_b), 32'd0);

        // Back-pressure: rd_ready low for 200 cycles after the first data byte.
        tx_b = tx_q.size(); rx_b = rx_q.size(); dn_b = n_done; cs_b = n_cs_falls;
        st_b = n_starts; ss_b = n_stall_start;
        @(posedge clk); #1;
        bus.rd_ready = 1'b0;
        do_req(24'h000010, 16'd4, "t3");
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (bus.rd_valid) ok = 1'b1;
        end
        check("t3_first_valid", 32'(ok), 32'd1);
        cs_high = 0; start_high = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cs) cs_high++;
            if (bus.spi_start) start_high++;
        end
        check("t3_stall_cs_high", 32'(cs_high), 32'd0);
        check("t3_stall_starts", 32'(start_high), 32'd0);
        check("t3_stall_valid", 32'(bus.rd_valid), 32'd1);
        check("t3_stall_data", 32'(bus.rd_data), 32'h2C);
        check("t3_stall_tx", 32'(tx_q.size() - tx_b), 32'd5);
        @(posedge clk); #1;
        bus.rd_ready = 1'b1;
        wait_done(dn_b, 2000, "t3");
        exp = '{8'h2C, 8'h2D, 8'h2E, 8'h2F};
        cmp_bytes("t3_rx", 1'b1, rx_b, exp);
        check("t3_tx_total", 32'(tx_q.size() - tx_b), 32'd8);
        check("t3_starts", 32'(n_starts - st_b), 32'd8);
        check("t3_cs_windows", 32'(n_cs_falls - cs_b), 32'd1);
        check("t3_start_with_valid", 32'(n_stall_start - ss_b), 32'd0);

        // Asynchronous reset while byte index 2 is in flight.
        tx_b = tx_q.size();
        do_req(24'h00AB40, 16'd3, "t4");
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (tx_q.size() >= tx_b + 3) ok = 1'b1;
        end
        check("t4_reach_byte2", 32'(ok), 32'd1);
        check("t4_pre_cs", 32'(bus.cs), 32'd0);
        check("t4_pre_data_in", 32'(bus.spi_data_in), 32'hAB);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("t4_async");
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("t4_release_req_ready", 32'(bus.req_ready), 32'd1);
        tx_b = tx_q.size(); rx_b = rx_q.size(); dn_b = n_done;
        do_req(24'h000020, 16'd1, "t4b");
        wait_done(dn_b, 2000, "t4b");
        exp = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00};
        cmp_bytes("t4b_tx", 1'b0, tx_b, exp);
        exp = '{8'h1C};
        cmp_bytes("t4b_rx", 1'b1, rx_b, exp);

        // A second request offered while busy is ignored.
        tx_b = tx_q.size(); rx_b = rx_q.size(); dn_b = n_done; cs_b = n_cs_falls;
        do_req(24'h000030, 16'd1, "t5");
        repeat (5) @(posedge clk);
        #1;
        check("t5_ready_while_busy", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 24'h0000AA;
        bus.req_len   = 16'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_done(dn_b, 2000, "t5");
        repeat (100) @(negedge clk);
        check("t5_done_pulses", 32'(n_done - dn_b), 32'd1);
        check("t5_cs_windows", 32'(n_cs_falls - cs_b), 32'd1);
        exp = '{8'h03, 8'h00, 8'h00, 8'h30, 8'h00};
        cmp_bytes("t5_tx", 1'b0, tx_b, exp);
        exp = '{8'h0C};
        cmp_bytes("t5_rx", 1'b1, rx_b, exp);

        check("start_held_across_byte", 32'(n_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
